seq_booth_multiplier: RTL
=========================

# seq_booth_multiplier

Sequential radix-2 Booth multiplier, parametrised in operand width, with a per-operation signed/unsigned mode and a start/done handshake. It is the multi-cycle successor to the team's combinational 32×32 signed multiplier. It trades latency for area: one adder of width WIDTH+1 replaces the full array. It sits on the datapath behind the ALU issue logic and produces a full double-width product.

## Interface
- WIDTH, 32, operand width in bits (≥ 2); product width is 2*WIDTH.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only in IDLE or DONE.
- signed_mode  in  1  1 = operands two's complement, 0 = unsigned; latched with start.
- M  in  WIDTH  multiplicand; latched with start.
- Q  in  WIDTH  multiplier; latched with start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse; P valid.
- P  out  2*WIDTH  product; held until the next accepted start.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 latches M, Q and signed_mode. Operands are extended to WIDTH+1 bits: sign-extended when signed_mode=1, zero-extended otherwise. The accumulator A (WIDTH+1) is cleared, q_-1 is set to 0, and the iteration counter is set to WIDTH+1. Next state is RUN.
- RUN, once per cycle:
  - Pair {Q[0], q_-1} selects the A update: 01 → A+M, 10 → A−M, 00/11 → A unchanged.
  - Then {A,Q,q_-1} is arithmetic-shifted right by one, and the counter decrements.
  - After the (WIDTH+1)th step, P is loaded with the low 2*WIDTH bits of {A,Q} and the state moves to DONE.
- DONE: done=1 for exactly one cycle.
  - start=1 in DONE is accepted as in IDLE (back-to-back, next state RUN).
  - Otherwise the next state is IDLE.
- start in RUN is ignored; inputs may change freely during RUN without effect.
- Arithmetic: all internal add/sub is modulo 2^(WIDTH+1). The result is exact for every operand pair in both modes, including the most-negative × most-negative signed case.
- rst (any time, including mid-RUN) forces the following values immediately, and any operation in flight is discarded:
  - state to IDLE;
  - busy=0, done=0;
  - P=0, A=0, counter=0.

## Timing
- Start accepted at the rising edge ending cycle 0.
- busy is high in cycles 1..WIDTH+1.
- done is high and P is updated in cycle WIDTH+2. Latency is WIDTH+2 cycles; it is 34 for WIDTH=32.
- Back-to-back throughput: one result per WIDTH+2 cycles, with start held high through DONE.
- P changes only on the edge entering DONE, or on reset. It is stable in IDLE, RUN, and after done.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- MULT_ZERO_SKIP_EN defined: in IDLE/DONE, if the accepted M==0 or Q==0, the state goes directly to DONE. P=0 and done is asserted in cycle 1, with no RUN cycles and busy held low.
- Undefined: zero operands take the full WIDTH+2 cycle path; the result is still P=0.

## Test plan
- WIDTH=32, signed_mode=1, M=616, Q=−81 (0xFFFFFFAF), start pulse.
  - Expect busy cycles 1–33, done in cycle 34, P=0xFFFFFFFFFFFF3D18 (−49896).
- Same operands with signed_mode=0.
  - Expect P=0x00000267FFFF3D18.
- Corner cases:
  - Signed M=Q=0x80000000 → P=0x4000000000000000.
  - Unsigned M=Q=0xFFFFFFFF → P=0xFFFFFFFE00000001.
  - Signed 0xFFFFFFFF×1 → P=0xFFFFFFFFFFFFFFFF.
- Back-to-back: start held high.
  - Expect done every 34 cycles with the correct products.
  - Operand changes during RUN and start pulses during RUN have no effect on the current result.
- Reset mid-op: assert rst in cycle 10 of a RUN.
  - Expect busy=0, done=0, P=0 asynchronously.
  - After release, a new 616×−81 operation completes correctly in 34 cycles.
- M=0, Q=1234.
  - With MULT_ZERO_SKIP_EN: done in cycle 1, P=0, busy never high.
  - Without: done in cycle 34, P=0.

Source files
------------

// File: rtl/seq_booth_multiplier.sv
`default_nettype none
// ============================================================================
// Module      : seq_booth_multiplier
// Description : Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH,
//               per-operation signed/unsigned mode, start/done handshake.
//               Optional MULT_ZERO_SKIP_EN: zero operands finish without RUN.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_booth_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     M,
    input  logic [WIDTH-1:0]     Q,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   P
);

    localparam int CW = $clog2(WIDTH + 2);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [WIDTH:0]     a_q, a_d;
    logic [WIDTH:0]     m_q, m_d;
    logic [WIDTH:0]     q_q, q_d;
    logic               qm1_q, qm1_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic               busy_q, done_q;

    logic               w_accept;
    logic               w_zero;
    logic [WIDTH:0]     w_m_ext;
    logic [WIDTH:0]     w_q_ext;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_a_shift;
    logic [WIDTH:0]     w_q_shift;

    assign w_accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign w_m_ext  = signed_mode ? {M[WIDTH-1], M} : {1'b0, M};
    assign w_q_ext  = signed_mode ? {Q[WIDTH-1], Q} : {1'b0, Q};

`ifdef MULT_ZERO_SKIP_EN
    assign w_zero = (M == '0) || (Q == '0);
`else
    assign w_zero = 1'b0;
`endif

    // Booth recoding of {Q[0], q_-1}; sums wrap modulo 2^(WIDTH+1).
    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   w_sum = a_q + m_q;
            2'b10:   w_sum = a_q - m_q;
            default: w_sum = a_q;
        endcase
    end

    assign w_a_shift = {w_sum[WIDTH], w_sum[WIDTH:1]};
    assign w_q_shift = {w_sum[0], q_q[WIDTH:1]};

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        m_d     = m_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    m_d   = w_m_ext;
                    q_d   = w_q_ext;
                    a_d   = '0;
                    qm1_d = 1'b0;
                    cnt_d = CW'(WIDTH + 1);
                    if (w_zero) begin
                        p_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                a_d   = w_a_shift;
                q_d   = w_q_shift;
                qm1_d = q_q[0];
                cnt_d = cnt_q - CW'(1);
                // Last step: the extended product's top two bits are redundant.
                if (cnt_q == CW'(1)) begin
                    p_d     = {w_a_shift[WIDTH-2:0], w_q_shift};
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            m_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            cnt_q   <= '0;
            p_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            m_q     <= m_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
            busy_q  <= (state_d == S_RUN);
            done_q  <= (state_d == S_DONE);
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign P    = p_q;

endmodule
`default_nettype wire
